alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
- REQ-001: clk  input  1  -- single clock; all state updates on rising edge.
- REQ-002: rst_b  input  1  -- asynchronous, active-low reset.
- REQ-003: req_valid  input  1  -- request present.
- REQ-004: req_ready  output  1  -- sequencer can accept; high only in IDLE.
- REQ-005: req_op  input  alu_op_t  -- operation.
- REQ-006: req_wide  input  1  -- 1 = 16-bit operation. Honoured only for alu_ADD, alu_SUB, alu_ADC, alu_SBC; ignored for all other ops.
- REQ-007: req_a, req_b  input  16 each  -- operands; only [7:0] used when narrow.
- REQ-008: alu_op_A, alu_op_B  output  8 each  -- byte operands driven to the ALU.
- REQ-009: alu_op_code  output  alu_op_t  -- ALU operation.
- REQ-010: alu_curr_flags  output  4  -- flags {Z N H C} driven to the ALU.
- REQ-011: alu_result  input  8  -- combinational ALU result.
- REQ-012: alu_next_flags  input  4  -- combinational ALU flags.
- REQ-013: rsp_valid  output  1  -- response present.
- REQ-014: rsp_ready  input  1  -- consumer accepts the response.
- REQ-015: rsp_result  output  16  -- result; [15:8] = 0 for narrow ops.
- REQ-016: rsp_flags  output  4  -- committed flags.
- REQ-017: flags_q  output  4  -- architectural F register {Z N H C}.
- REQ-018: flags_we, flags_wdata  input  1/4  -- direct F write (POP AF style).

Function
- REQ-019: FSM states: IDLE, LO, HI, RESP.
- REQ-020: IDLE with req_valid: latch the request and go to LO.
- REQ-021: LO pass:
  - ALU driven with req_a[7:0], req_b[7:0], latched op, and flags_q.
  - Result and flags captured into lo_res and lo_flags.
  - Next state is HI if wide, else RESP.
- REQ-022: HI pass:
  - ALU driven with [15:8] operand bytes and lo_flags as curr_flags.
  - Op mapping: ADD->ADC, SUB->SBC, ADC->ADC, SBC->SBC.
  - Result and flags captured into hi_res and hi_flags; next state RESP.
- REQ-023: Wide flags result = {flags_q[3] (Z preserved from before the op), hi_flags[2:0]}. Narrow flags result = lo_flags.
- REQ-024: On entry to RESP, flags_q is loaded with the flags result in the same edge; rsp_flags equals that value.
- REQ-025: RESP holds rsp_valid, rsp_result and rsp_flags stable until rsp_ready; on rsp_ready go to IDLE.
- REQ-026: Handshake latency: narrow request accepted at edge N gives rsp_valid at N+2; wide gives N+3. Maximum throughput is 1 request per 3 (narrow) or 4 (wide) cycles.
- REQ-027: In IDLE, alu_op_code = alu_NOP and operands = 0.
- REQ-028: flags_we is honoured only in IDLE and writes flags_q at that edge. A request accepted in the same cycle sees the written value in LO.
- REQ-029: flags_we outside IDLE is ignored.
- REQ-030: req_valid outside IDLE is not accepted, since req_ready = 0.

Reset
- REQ-031: rst_b low asynchronously forces:
  - state = IDLE; flags_q = 0; latches cleared.
  - rsp_valid = 0; rsp_result = 0; rsp_flags = 0.
- REQ-032: Reset mid-operation (LO, HI or RESP) abandons the operation; flags_q is not updated by the abandoned op.
- REQ-033: req_ready = 1 on the first cycle after rst_b deasserts.

Structure
- REQ-034: alu_op_t and a new seq_state_t enum (IDLE, LO, HI, RESP) live in the shared ALU package.
- REQ-035: Flag bit-position constants (FLAG_Z = 3, FLAG_N = 2, FLAG_H = 1, FLAG_C = 0) live in the shared ALU package.
- REQ-036: The ALU is instantiated outside this block; no sub-module is required. The op-mapping function for the HI pass lives in the shared package.

Verification (bench instantiates the real alu)
- REQ-037: Narrow alu_ADD, A = 0xFF, B = 0xFF, flags 0 -> rsp_result 0x00FE, rsp_flags 4'b0011, rsp_valid 2 cycles after accept.
- REQ-038: Narrow alu_SUB, A = 0x00, B = 0xFF -> rsp_result 0x0001, rsp_flags 4'b0111.
- REQ-039: Wide alu_ADD, A = 0x0FFF, B = 0x0001, flags_q = 4'b1000 -> rsp_result 0x1000, rsp_flags 4'b1010, rsp_valid 3 cycles after accept.
- REQ-040: flags_we with 4'b0001 in IDLE, same-cycle alu_ADC request with A = 0x2B, B = 0x1C -> rsp_result 0x0048, rsp_flags 4'b0010.
- REQ-041: rsp_ready held low 5 cycles -> outputs stable, req_ready = 0, flags_q written exactly once.
- REQ-042: rst_b pulsed low during HI -> all outputs 0 immediately, flags_q = 0, next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package.
// Contents: ALU op enum, sequencer state enum, flag bit positions {Z N H C},
// and helpers for splitting a 16-bit op into two byte passes.
package alu_pkg;

  typedef enum logic [3:0] {
    alu_NOP, alu_ADD, alu_ADC, alu_SUB, alu_SBC, alu_AND, alu_OR, alu_XOR
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} seq_state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  // High byte must chain the low byte's carry/borrow.
  function automatic alu_op_t hi_op(input alu_op_t op);
    case (op)
      alu_ADD, alu_ADC: hi_op = alu_ADC;
      alu_SUB, alu_SBC: hi_op = alu_SBC;
      default:          hi_op = op;
    endcase
  endfunction

  // Only carry-chained arithmetic can be widened.
  function automatic logic is_wide_op(input alu_op_t op);
    is_wide_op = (op == alu_ADD) || (op == alu_ADC) ||
                 (op == alu_SUB) || (op == alu_SBC);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU with {Z N H C} flags.
// Ports: a, b     - byte operands
//        op       - operation
//        flags_in - current flags (carry-in for ADC/SBC; passed through on NOP)
//        result   - byte result
//        flags_out- next flags
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_t    op,
  input  logic [3:0] flags_in,
  output logic [7:0] result,
  output logic [3:0] flags_out
);

  logic       cin;
  logic [8:0] w;
  logic [4:0] h5;

  always_comb begin
    cin       = ((op == alu_ADC) || (op == alu_SBC)) ? flags_in[FLAG_C] : 1'b0;
    w         = '0;
    h5        = '0;
    result    = '0;
    flags_out = flags_in;
    case (op)
      alu_ADD, alu_ADC: begin
        w  = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        h5 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, cin};
        result            = w[7:0];
        flags_out[FLAG_Z] = (w[7:0] == 8'h00);
        flags_out[FLAG_N] = 1'b0;
        flags_out[FLAG_H] = h5[4];
        flags_out[FLAG_C] = w[8];
      end
      alu_SUB, alu_SBC: begin
        // Bit 8 / bit 4 of the extended difference is the borrow out.
        w  = {1'b0, a} - {1'b0, b} - {8'h00, cin};
        h5 = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, cin};
        result            = w[7:0];
        flags_out[FLAG_Z] = (w[7:0] == 8'h00);
        flags_out[FLAG_N] = 1'b1;
        flags_out[FLAG_H] = h5[4];
        flags_out[FLAG_C] = w[8];
      end
      alu_AND, alu_OR, alu_XOR: begin
        if (op == alu_AND)     result = a & b;
        else if (op == alu_OR) result = a | b;
        else                   result = a ^ b;
        flags_out[FLAG_Z] = (result == 8'h00);
        flags_out[FLAG_N] = 1'b0;
        flags_out[FLAG_H] = (op == alu_AND);
        flags_out[FLAG_C] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences 8- and 16-bit ALU operations through an external byte ALU and
// owns the architectural flag register F {Z N H C}.
// Ports:
//   clk, rst_b                  - clock, async active-low reset
//   req_valid/ready, req_op, req_wide, req_a, req_b - request handshake
//   alu_op_A/B, alu_op_code, alu_curr_flags         - drive to external ALU
//   alu_result, alu_next_flags                      - from external ALU
//   rsp_valid/ready, rsp_result, rsp_flags          - response handshake
//   flags_q                     - architectural F register
//   flags_we, flags_wdata       - direct F write, honoured in IDLE only
// Flow: IDLE -> LO -> (HI if wide) -> RESP -> IDLE.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  alu_op_t     req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [7:0]  alu_op_A,
  output logic [7:0]  alu_op_B,
  output alu_op_t     alu_op_code,
  output logic [3:0]  alu_curr_flags,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_next_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  flags_q,
  input  logic        flags_we,
  input  logic [3:0]  flags_wdata
);

  seq_state_t  state_q, state_d;
  alu_op_t     op_q, op_d;
  logic        wide_q, wide_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [7:0]  lo_res_q, lo_res_d;
  logic [3:0]  lo_flags_q, lo_flags_d;
  logic [3:0]  flags_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      op_q         <= alu_NOP;
      wide_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      lo_res_q     <= '0;
      lo_flags_q   <= '0;
      flags_q      <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wide_q       <= wide_d;
      a_q          <= a_d;
      b_q          <= b_d;
      lo_res_q     <= lo_res_d;
      lo_flags_q   <= lo_flags_d;
      flags_q      <= flags_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // Next state. The response registers and F are written on the same edge
  // that enters RESP, so F only ever changes on a completed op or flags_we.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wide_d       = wide_q;
    a_d          = a_q;
    b_d          = b_q;
    lo_res_d     = lo_res_q;
    lo_flags_d   = lo_flags_q;
    flags_d      = flags_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (flags_we) flags_d = flags_wdata;
        if (req_valid) begin
          op_d    = req_op;
          wide_d  = req_wide && is_wide_op(req_op);
          a_d     = req_a;
          b_d     = req_b;
          state_d = LO;
        end
      end
      LO: begin
        lo_res_d   = alu_result;
        lo_flags_d = alu_next_flags;
        if (wide_q) begin
          state_d = HI;
        end else begin
          rsp_result_d = {8'h00, alu_result};
          rsp_flags_d  = alu_next_flags;
          flags_d      = alu_next_flags;
          state_d      = RESP;
        end
      end
      HI: begin
        // Z of a 16-bit op is not derivable from the high byte alone; keep
        // the pre-op Z and take N/H/C from the high pass.
        rsp_result_d = {alu_result, lo_res_q};
        rsp_flags_d  = {flags_q[FLAG_Z], alu_next_flags[FLAG_N:FLAG_C]};
        flags_d      = {flags_q[FLAG_Z], alu_next_flags[FLAG_N:FLAG_C]};
        state_d      = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive.
  always_comb begin
    alu_op_A       = '0;
    alu_op_B       = '0;
    alu_op_code    = alu_NOP;
    alu_curr_flags = flags_q;
    case (state_q)
      LO: begin
        alu_op_A    = a_q[7:0];
        alu_op_B    = b_q[7:0];
        alu_op_code = op_q;
      end
      HI: begin
        alu_op_A       = a_q[15:8];
        alu_op_B       = b_q[15:8];
        alu_op_code    = hi_op(op_q);
        alu_curr_flags = lo_flags_q;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer paired with the byte ALU.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk, rst_b;
  logic        req_valid, req_ready, req_wide;
  alu_op_t     req_op;
  logic [15:0] req_a, req_b;
  logic [7:0]  alu_op_A, alu_op_B, alu_result;
  alu_op_t     alu_op_code;
  logic [3:0]  alu_curr_flags, alu_next_flags;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags, flags_q, flags_wdata;
  logic        flags_we;

  int n_checks = 0;
  int n_err    = 0;

  alu_sequencer dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_wide(req_wide), .req_a(req_a), .req_b(req_b),
    .alu_op_A(alu_op_A), .alu_op_B(alu_op_B), .alu_op_code(alu_op_code),
    .alu_curr_flags(alu_curr_flags), .alu_result(alu_result),
    .alu_next_flags(alu_next_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .flags_q(flags_q),
    .flags_we(flags_we), .flags_wdata(flags_wdata)
  );

  alu u_alu (
    .a(alu_op_A), .b(alu_op_B), .op(alu_op_code), .flags_in(alu_curr_flags),
    .result(alu_result), .flags_out(alu_next_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Present a request #1 after an edge, let it be accepted on the next edge,
  // then count edges until rsp_valid is seen (bounded). cyc = 1 means the
  // consumer can take the response at accept-edge + 2.
  task automatic issue(input alu_op_t op, input logic wide,
                       input logic [15:0] a, input logic [15:0] b, output int cyc);
    req_op = op; req_wide = wide; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flags_we = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    flags_we = 1'b1; flags_wdata = f;
    @(posedge clk); #1;
    flags_we = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_flags, flags_q, alu_op_code, alu_op_A, alu_op_B} !== 41'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b res=%h fl=%b F=%b op=%0d A=%h B=%h required all 0",
               rsp_valid, rsp_result, rsp_flags, flags_q, alu_op_code, alu_op_A, alu_op_B);
    end
    rst_b = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_narrow_add;
    int cyc;
    rsp_ready = 1'b1;
    issue(alu_ADD, 1'b0, 16'h00FF, 16'h00FF, cyc);
    n_checks++;
    if (cyc !== 1) begin n_err++; $display("FAIL narrow_add_latency: got %0d required 1", cyc); end
    n_checks++;
    if ({rsp_result, rsp_flags, flags_q} !== {16'h00FE, 4'b0011, 4'b0011}) begin
      n_err++;
      $display("FAIL narrow_add: got res=%h fl=%b F=%b required 00fe 0011 0011", rsp_result, rsp_flags, flags_q);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL narrow_add_release: got ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_narrow_sub;
    int cyc;
    issue(alu_SUB, 1'b0, 16'h0000, 16'h00FF, cyc);
    n_checks++;
    if (cyc !== 1 || {rsp_result, rsp_flags} !== {16'h0001, 4'b0111}) begin
      n_err++;
      $display("FAIL narrow_sub: got cyc=%0d res=%h fl=%b required 1 0001 0111", cyc, rsp_result, rsp_flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide_add;
    int cyc;
    set_flags(4'b1000);
    issue(alu_ADD, 1'b1, 16'h0FFF, 16'h0001, cyc);
    n_checks++;
    if (cyc !== 2) begin n_err++; $display("FAIL wide_add_latency: got %0d required 2", cyc); end
    n_checks++;
    if ({rsp_result, rsp_flags, flags_q} !== {16'h1000, 4'b1010, 4'b1010}) begin
      n_err++;
      $display("FAIL wide_add: got res=%h fl=%b F=%b required 1000 1010 1010", rsp_result, rsp_flags, flags_q);
    end
    @(posedge clk); #1;
  endtask

  // F is 1010 here: Z=1 must survive a 16-bit op with a non-zero result.
  task automatic test_wide_sub;
    int cyc;
    issue(alu_SUB, 1'b1, 16'h1000, 16'h0001, cyc);
    n_checks++;
    if (cyc !== 2 || {rsp_result, rsp_flags} !== {16'h0FFF, 4'b1110}) begin
      n_err++;
      $display("FAIL wide_sub: got cyc=%0d res=%h fl=%b required 2 0fff 1110", cyc, rsp_result, rsp_flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide_ignored;
    int cyc;
    issue(alu_AND, 1'b1, 16'h12F0, 16'h343C, cyc);
    n_checks++;
    if (cyc !== 1 || {rsp_result, rsp_flags} !== {16'h0030, 4'b0010}) begin
      n_err++;
      $display("FAIL wide_ignored: got cyc=%0d res=%h fl=%b required 1 0030 0010", cyc, rsp_result, rsp_flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    int cyc;
    rsp_ready = 1'b0;
    issue(alu_XOR, 1'b0, 16'h00FF, 16'h00FF, cyc);
    n_checks++;
    if (cyc !== 1) begin n_err++; $display("FAIL stall_latency: got %0d required 1", cyc); end
    // Try to write F and start a new op while the response is held.
    req_valid = 1'b1; req_op = alu_ADD; req_a = 16'h0001; req_b = 16'h0001;
    flags_we = 1'b1; flags_wdata = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({rsp_valid, req_ready, rsp_result, rsp_flags, flags_q} !== {2'b10, 16'h0000, 4'b1000, 4'b1000}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b rdy=%b res=%h fl=%b F=%b required 1 0 0000 1000 1000",
                 i, rsp_valid, req_ready, rsp_result, rsp_flags, flags_q);
      end
    end
    req_valid = 1'b0; flags_we = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({req_ready, rsp_valid, alu_op_code, flags_q} !== {2'b10, alu_NOP, 4'b1000}) begin
      n_err++;
      $display("FAIL stall_release: got rdy=%b v=%b op=%0d F=%b required 1 0 0 1000",
               req_ready, rsp_valid, alu_op_code, flags_q);
    end
  endtask

  task automatic test_flags_we_same_cycle;
    int cyc;
    flags_we = 1'b1; flags_wdata = 4'b0001;
    issue(alu_ADC, 1'b0, 16'h002B, 16'h001C, cyc);
    n_checks++;
    if (cyc !== 1 || {rsp_result, rsp_flags, flags_q} !== {16'h0048, 4'b0010, 4'b0010}) begin
      n_err++;
      $display("FAIL flags_we_adc: got cyc=%0d res=%h fl=%b F=%b required 1 0048 0010 0010",
               cyc, rsp_result, rsp_flags, flags_q);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    req_op = alu_ADD; req_wide = 1'b1; req_a = 16'h00FF; req_b = 16'h0001; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({alu_op_code, alu_op_A, alu_curr_flags} !== {alu_ADC, 8'h00, 4'b1011}) begin
      n_err++;
      $display("FAIL hi_pass_drive: got op=%0d A=%h cf=%b required %0d 00 1011",
               alu_op_code, alu_op_A, alu_curr_flags, alu_ADC);
    end
    rst_b = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_flags, flags_q, alu_op_code, alu_op_A, req_ready} !== {34'd0, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b res=%h fl=%b F=%b op=%0d A=%h rdy=%b required 0 0000 0000 0000 0 00 1",
               rsp_valid, rsp_result, rsp_flags, flags_q, alu_op_code, alu_op_A, req_ready);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    #1;
    issue(alu_ADD, 1'b0, 16'h0001, 16'h0002, cyc);
    n_checks++;
    if (cyc !== 1 || {rsp_result, rsp_flags, flags_q} !== {16'h0003, 4'b0000, 4'b0000}) begin
      n_err++;
      $display("FAIL post_reset_op: got cyc=%0d res=%h fl=%b F=%b required 1 0003 0000 0000",
               cyc, rsp_result, rsp_flags, flags_q);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_b = 1'b0; req_valid = 1'b0; req_op = alu_NOP; req_wide = 1'b0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0; flags_we = 1'b0; flags_wdata = '0;
    test_reset;
    test_narrow_add;
    test_narrow_sub;
    test_wide_add;
    test_wide_sub;
    test_wide_ignored;
    test_stall;
    test_flags_we_same_cycle;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
